// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM. Port 0 (CPU) has fixed priority.
// Port 1 gets a forced grant after MAX_WAIT blocked cycles, so it cannot starve.
module ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_wen,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wen,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_p0_rvalid;
    logic       r_p1_rvalid;
    logic       w_force;
    logic       w_p0_gnt;
    logic       w_p1_gnt;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    assign w_force  = p1_req & (r_wait_cnt == MAX_WAIT_C);
    assign w_p1_gnt = rst_n & p1_req & (w_force | ~p0_req);
    assign w_p0_gnt = rst_n & p0_req & ~w_p1_gnt;

    assign p0_gnt    = w_p0_gnt;
    assign p1_gnt    = w_p1_gnt;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rvalid ? ram_out : '0;
    assign p1_rdata  = r_p1_rvalid ? ram_out : '0;

    // NOTE: every output gets a default first so the mux cannot infer a latch.
    always_comb begin
        ram_addr = '0;
        ram_in   = '0;
        ram_wen  = 1'b0;
        if (w_p1_gnt) begin
            ram_addr = p1_addr;
            ram_in   = p1_wdata;
            ram_wen  = p1_wen;
        end else if (w_p0_gnt) begin
            ram_addr = p0_addr;
            ram_in   = p0_wdata;
            ram_wen  = p0_wen;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= 4'd0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
        end else begin
            r_p0_rvalid <= w_p0_gnt & ~p0_wen;
            r_p1_rvalid <= w_p1_gnt & ~p1_wen;
            if (w_p1_gnt || !p1_req)
                r_wait_cnt <= 4'd0;
            else if (r_wait_cnt < MAX_WAIT_C)
                r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small clocked RAM model behind the mux.
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_wen = 1'b0;
    logic [15:0] p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_wen = 1'b0;
    logic [15:0] p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_in;
    logic        ram_wen;
    logic [31:0] ram_out = '0;
    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_in(ram_in), .ram_wen(ram_wen), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // Clocked single-port RAM: read returns the value stored before this edge's write.
    always_ff @(posedge clk) begin
        ram_out <= mem[ram_addr[7:0]];
        if (ram_wen) mem[ram_addr[7:0]] <= ram_in;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic wen, input logic [15:0] a, input logic [31:0] d);
        p0_req = req; p0_wen = wen; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic wen, input logic [15:0] a, input logic [31:0] d);
        p1_req = req; p1_wen = wen; p1_addr = a; p1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h20] = 32'h12345678;

        // Reset held with both requests high.
        set_p0(1'b1, 1'b1, 16'h0040, 32'hAAAA5555);
        set_p1(1'b1, 1'b1, 16'h0050, 32'h5555AAAA);
        tick(); #2;
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_p1_gnt", p1_gnt, 0);
        check("rst_ram_wen", ram_wen, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_p0_rvalid", p0_rvalid, 0);
        check("rst_p1_rvalid", p1_rvalid, 0);

        // Release mid-cycle with only port 0 requesting: grant appears immediately.
        set_p1(1'b0, 1'b0, 16'h0, 32'h0);
        set_p0(1'b0, 1'b0, 16'h0, 32'h0);
        rst_n = 1'b1;
        p0_req = 1'b1;
        #1;
        check("rel_p0_gnt", p0_gnt, 1);
        check("rel_p1_gnt", p1_gnt, 0);

        // Port 0 write then read of 0x0010.
        tick();
        set_p0(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
        #2;
        check("p0w_gnt", p0_gnt, 1);
        check("p0w_ram_wen", ram_wen, 1);
        check("p0w_ram_addr", ram_addr, 16'h0010);
        check("p0w_ram_in", ram_in, 32'hDEADBEEF);
        tick();
        set_p0(1'b1, 1'b0, 16'h0010, 32'h0);
        #2;
        check("p0w_no_rvalid", p0_rvalid, 0);
        check("p0r_gnt", p0_gnt, 1);
        check("p0r_ram_wen", ram_wen, 0);
        tick();
        set_p0(1'b0, 1'b0, 16'h0, 32'h0);
        #2;
        check("p0r_rvalid", p0_rvalid, 1);
        check("p0r_rdata", p0_rdata, 32'hDEADBEEF);
        check("p0r_p1_rvalid", p1_rvalid, 0);
        check("p0r_p1_rdata", p1_rdata, 0);
        check("p0r_p1_gnt", p1_gnt, 0);
        check("idle_ram_addr", ram_addr, 0);

        // Port 1 read of preloaded 0x0020.
        tick();
        set_p1(1'b1, 1'b0, 16'h0020, 32'h0);
        #2;
        check("p1r_gnt", p1_gnt, 1);
        check("p1r_ram_addr", ram_addr, 16'h0020);
        check("p1r_p0_rvalid_drop", p0_rvalid, 0);
        tick();
        set_p1(1'b0, 1'b0, 16'h0, 32'h0);
        #2;
        check("p1r_rvalid", p1_rvalid, 1);
        check("p1r_rdata", p1_rdata, 32'h12345678);
        check("p1r_p0_rdata", p0_rdata, 0);

        // Starvation: both held, p1 forced in at cycles 4 and 9.
        tick();
        set_p0(1'b1, 1'b1, 16'h0060, 32'h0000C0DE);
        set_p1(1'b1, 1'b1, 16'h0070, 32'h0000BEEF);
        for (int c = 0; c < 10; c++) begin
            #2;
            check($sformatf("starve_p1_gnt_c%0d", c), p1_gnt, (c == 4 || c == 9) ? 1 : 0);
            check($sformatf("starve_p0_gnt_c%0d", c), p0_gnt, (c == 4 || c == 9) ? 0 : 1);
            if (c == 4)
                check("starve_ram_addr_c4", ram_addr, 16'h0070);
            tick();
        end

        // Port 1 withdraw: 3 blocked cycles, 1 low, then grant 4 cycles after re-assertion.
        set_p1(1'b0, 1'b0, 16'h0, 32'h0);
        tick();
        set_p1(1'b1, 1'b0, 16'h0020, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("wd_pre_p1_gnt_c%0d", c), p1_gnt, 0);
            tick();
        end
        p1_req = 1'b0;
        #2;
        check("wd_low_p1_gnt", p1_gnt, 0);
        tick();
        p1_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("wd_post_p1_gnt_c%0d", c), p1_gnt, (c == 4) ? 1 : 0);
            tick();
        end

        // Write by port 0 then read by port 1 of the same address on the next cycle.
        set_p1(1'b0, 1'b0, 16'h0, 32'h0);
        set_p0(1'b1, 1'b1, 16'h0030, 32'hCAFEF00D);
        #2;
        check("wr_then_rd_p0_gnt", p0_gnt, 1);
        tick();
        set_p0(1'b0, 1'b0, 16'h0, 32'h0);
        set_p1(1'b1, 1'b0, 16'h0030, 32'h0);
        tick();
        set_p1(1'b0, 1'b0, 16'h0, 32'h0);
        #2;
        check("wr_then_rd_p1_rdata", p1_rdata, 32'hCAFEF00D);

        // Back-to-back port 0 reads give rvalid on consecutive cycles.
        tick();
        set_p0(1'b1, 1'b0, 16'h0010, 32'h0);
        tick();
        set_p0(1'b1, 1'b0, 16'h0020, 32'h0);
        #2;
        check("b2b_rdata0", p0_rdata, 32'hDEADBEEF);
        tick();
        set_p0(1'b0, 1'b0, 16'h0, 32'h0);
        #2;
        check("b2b_rvalid1", p0_rvalid, 1);
        check("b2b_rdata1", p0_rdata, 32'h12345678);

        // Async reset mid-read on port 1, with counter built up beforehand.
        tick();
        set_p0(1'b1, 1'b1, 16'h0060, 32'h1);
        set_p1(1'b1, 1'b0, 16'h0020, 32'h0);
        tick(); tick();
        p0_req = 1'b0;
        #2;
        check("ar_p1_gnt", p1_gnt, 1);
        rst_n = 1'b0;
        #1;
        check("ar_p1_gnt_in_rst", p1_gnt, 0);
        tick();
        set_p1(1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        check("ar_p1_rvalid_in_rst", p1_rvalid, 0);
        rst_n = 1'b1;
        tick();
        check("ar_p1_rvalid_after", p1_rvalid, 0);
        check("ar_wait_cnt", dut.r_wait_cnt, 0);
        // Counter restarted: with both requesting, port 0 wins for four cycles.
        set_p0(1'b1, 1'b1, 16'h0060, 32'h2);
        set_p1(1'b1, 1'b1, 16'h0070, 32'h3);
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("ar_post_p1_gnt_c%0d", c), p1_gnt, (c == 4) ? 1 : 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
